// File: rtl/matching_engine.sv
`default_nettype none
// ============================================================================
// Module      : matching_engine
// Description : Top-of-book matching engine. It takes one order at a time over
//               a valid/ready handshake and holds one resting bid and one
//               resting ask. Each incoming order is checked against the
//               opposite side. On a cross, the engine pulses match_flag for one
//               cycle and reports buy/sell price and traded quantity. Any
//               unfilled remainder rests on the book if it improves its side.
//               Otherwise the remainder is dropped.
// Ports       : clk, reset (async, active-low)
//               enable, order_valid/side/price/qty  -> order intake
//               order_ready                         <- engine idle
//               match_flag, buy_price, sell_price, match_qty <- trade report
//               best_bid/bid_qty/bid_valid, best_ask/ask_qty/ask_valid <- book
//               trade_count                         <- saturating trade count
// Revision    : 1.0 - initial release
// ============================================================================
module matching_engine #(
    parameter int PRICE_W = 8,
    parameter int QTY_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               order_valid,
    input  logic               order_side,
    input  logic [PRICE_W-1:0] order_price,
    input  logic [QTY_W-1:0]   order_qty,
    output logic               order_ready,
    output logic               match_flag,
    output logic [PRICE_W-1:0] buy_price,
    output logic [PRICE_W-1:0] sell_price,
    output logic [QTY_W-1:0]   match_qty,
    output logic [PRICE_W-1:0] best_bid,
    output logic               bid_valid,
    output logic [PRICE_W-1:0] best_ask,
    output logic               ask_valid,
    output logic [QTY_W-1:0]   bid_qty,
    output logic [QTY_W-1:0]   ask_qty,
    output logic [15:0]        trade_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        MATCH = 2'd2,
        REST  = 2'd3
    } state_t;

    localparam logic [15:0] c_trade_max = 16'hFFFF;

    state_t             r_state;
    logic               r_side;     // 0 = buy, 1 = sell
    logic [PRICE_W-1:0] r_price;
    logic [QTY_W-1:0]   r_qty;      // in-flight quantity, later the remainder

    logic               w_cross;
    logic [QTY_W-1:0]   w_opp_qty;
    logic [QTY_W-1:0]   w_trade_qty;
    logic [QTY_W-1:0]   w_remain;
    logic               w_better;

    // A buy hits the ask and a sell hits the bid. Equal prices count as a cross.
    assign w_cross     = r_side ? (bid_valid && (r_price <= best_bid))
                                : (ask_valid && (r_price >= best_ask));
    assign w_opp_qty   = r_side ? bid_qty : ask_qty;
    assign w_trade_qty = (r_qty < w_opp_qty) ? r_qty : w_opp_qty;
    // match_qty already holds this trade's size during the MATCH cycle.
    assign w_remain    = r_qty - match_qty;
    // An order replaces its own side only if that side is empty or the order
    // is strictly better: a higher bid or a lower ask.
    assign w_better    = r_side ? (!ask_valid || (r_price < best_ask))
                                : (!bid_valid || (r_price > best_bid));

    assign order_ready = (r_state == IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_side      <= 1'b0;
            r_price     <= '0;
            r_qty       <= '0;
            match_flag  <= 1'b0;
            buy_price   <= '0;
            sell_price  <= '0;
            match_qty   <= '0;
            best_bid    <= '0;
            bid_valid   <= 1'b0;
            bid_qty     <= '0;
            best_ask    <= '0;
            ask_valid   <= 1'b0;
            ask_qty     <= '0;
            trade_count <= '0;
        end else begin
            match_flag <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (order_valid && enable) begin
                        r_side  <= order_side;
                        r_price <= order_price;
                        r_qty   <= order_qty;
                        r_state <= EVAL;
                    end
                end
                EVAL: begin
                    if (r_qty == '0) begin
                        r_state <= IDLE;
                    end else if (w_cross) begin
                        buy_price  <= r_side ? best_bid : r_price;
                        sell_price <= r_side ? r_price  : best_ask;
                        match_qty  <= w_trade_qty;
                        match_flag <= 1'b1;
                        r_state    <= MATCH;
                    end else begin
                        r_state <= REST;
                    end
                end
                MATCH: begin
                    if (trade_count != c_trade_max) begin
                        trade_count <= trade_count + 16'd1;
                    end
                    if (r_side) begin
                        if (bid_qty == match_qty) begin
                            bid_valid <= 1'b0;
                            best_bid  <= '0;
                            bid_qty   <= '0;
                        end else begin
                            bid_qty <= bid_qty - match_qty;
                        end
                    end else begin
                        if (ask_qty == match_qty) begin
                            ask_valid <= 1'b0;
                            best_ask  <= '0;
                            ask_qty   <= '0;
                        end else begin
                            ask_qty <= ask_qty - match_qty;
                        end
                    end
                    r_qty   <= w_remain;
                    r_state <= (w_remain != '0) ? REST : IDLE;
                end
                REST: begin
                    if (w_better) begin
                        if (r_side) begin
                            ask_valid <= 1'b1;
                            best_ask  <= r_price;
                            ask_qty   <= r_qty;
                        end else begin
                            bid_valid <= 1'b1;
                            best_bid  <= r_price;
                            bid_qty   <= r_qty;
                        end
                    end
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matching_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_matching_engine
// Description : Directed self-checking bench for matching_engine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matching_engine;

    localparam int PRICE_W = 8;
    localparam int QTY_W   = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               enable = 1'b0;
    logic               order_valid = 1'b0;
    logic               order_side = 1'b0;
    logic [PRICE_W-1:0] order_price = '0;
    logic [QTY_W-1:0]   order_qty = '0;
    logic               order_ready;
    logic               match_flag;
    logic [PRICE_W-1:0] buy_price;
    logic [PRICE_W-1:0] sell_price;
    logic [QTY_W-1:0]   match_qty;
    logic [PRICE_W-1:0] best_bid;
    logic               bid_valid;
    logic [PRICE_W-1:0] best_ask;
    logic               ask_valid;
    logic [QTY_W-1:0]   bid_qty;
    logic [QTY_W-1:0]   ask_qty;
    logic [15:0]        trade_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Results captured by send_order.
    int                 r_cycles;
    int                 r_flags;
    int                 r_flag_cycle;
    logic [PRICE_W-1:0] r_buy;
    logic [PRICE_W-1:0] r_sell;
    logic [QTY_W-1:0]   r_mqty;

    matching_engine #(.PRICE_W(PRICE_W), .QTY_W(QTY_W)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .order_valid(order_valid), .order_side(order_side),
        .order_price(order_price), .order_qty(order_qty),
        .order_ready(order_ready), .match_flag(match_flag),
        .buy_price(buy_price), .sell_price(sell_price), .match_qty(match_qty),
        .best_bid(best_bid), .bid_valid(bid_valid),
        .best_ask(best_ask), .ask_valid(ask_valid),
        .bid_qty(bid_qty), .ask_qty(ask_qty), .trade_count(trade_count)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Present one order at a negedge and wait for the engine to return to
    // idle. The cycle count runs from the accept edge to the first idle
    // sample. Every match_flag pulse is recorded.
    task automatic send_order(input logic side, input int price, input int qty);
        bit done;
        @(negedge clk);
        order_valid = 1'b1;
        order_side  = side;
        order_price = PRICE_W'(price);
        order_qty   = QTY_W'(qty);
        @(posedge clk);
        @(negedge clk);
        order_valid = 1'b0;
        r_cycles = 1; r_flags = 0; r_flag_cycle = 0; done = 0;
        r_buy = '0; r_sell = '0; r_mqty = '0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(posedge clk);
            @(negedge clk);
            r_cycles++;
            if (match_flag === 1'b1) begin
                r_flags++;
                r_flag_cycle = r_cycles;
                r_buy  = buy_price;
                r_sell = sell_price;
                r_mqty = match_qty;
            end
            if (order_ready === 1'b1) done = 1;
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL order_timeout: order_ready=%b after %0d cycles, required 1", order_ready, r_cycles);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (order_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", order_ready); end
        n_checks++; if (match_flag !== 1'b0) begin n_fail++; $display("FAIL reset_flag: got %b want 0", match_flag); end
        n_checks++; if ({bid_valid, ask_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b want 00", {bid_valid, ask_valid}); end
        n_checks++; if ({best_bid, best_ask, bid_qty, ask_qty} !== 24'h0) begin n_fail++; $display("FAIL reset_book: got %h want 0", {best_bid, best_ask, bid_qty, ask_qty}); end
        n_checks++; if ({buy_price, sell_price, match_qty} !== 20'h0) begin n_fail++; $display("FAIL reset_trade: got %h want 0", {buy_price, sell_price, match_qty}); end
        n_checks++; if (trade_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", trade_count); end
    endtask

    task automatic test_rest_bid();
        send_order(1'b0, 50, 3);
        n_checks++; if (r_flags !== 0) begin n_fail++; $display("FAIL rest_flag: got %0d pulses want 0", r_flags); end
        n_checks++; if (r_cycles !== 3) begin n_fail++; $display("FAIL rest_cycles: got %0d want 3", r_cycles); end
        n_checks++; if ({bid_valid, best_bid, bid_qty} !== {1'b1, 8'd50, 4'd3}) begin n_fail++; $display("FAIL rest_bid: got v=%b p=%0d q=%0d want 1/50/3", bid_valid, best_bid, bid_qty); end
        n_checks++; if (ask_valid !== 1'b0) begin n_fail++; $display("FAIL rest_ask: got %b want 0", ask_valid); end
    endtask

    task automatic test_sell_cross();
        send_order(1'b1, 48, 2);
        n_checks++; if (r_flags !== 1) begin n_fail++; $display("FAIL cross_pulses: got %0d want 1", r_flags); end
        n_checks++; if (r_flag_cycle !== 2) begin n_fail++; $display("FAIL cross_flag_cycle: got %0d want 2", r_flag_cycle); end
        n_checks++; if ({r_buy, r_sell, r_mqty} !== {8'd50, 8'd48, 4'd2}) begin n_fail++; $display("FAIL cross_trade: got %0d/%0d/%0d want 50/48/2", r_buy, r_sell, r_mqty); end
        n_checks++; if (r_cycles !== 3) begin n_fail++; $display("FAIL cross_cycles: got %0d want 3", r_cycles); end
        n_checks++; if ({bid_valid, best_bid, bid_qty} !== {1'b1, 8'd50, 4'd1}) begin n_fail++; $display("FAIL cross_bid: got v=%b p=%0d q=%0d want 1/50/1", bid_valid, best_bid, bid_qty); end
        n_checks++; if (trade_count !== 16'd1) begin n_fail++; $display("FAIL cross_count: got %0d want 1", trade_count); end
        n_checks++; if ({buy_price, sell_price, match_qty} !== {8'd50, 8'd48, 4'd2}) begin n_fail++; $display("FAIL cross_hold: got %0d/%0d/%0d want 50/48/2", buy_price, sell_price, match_qty); end
    endtask

    task automatic test_equal_cross_remainder();
        // Book holds bid 50x1. A sell at 60 does not cross and rests as an ask.
        send_order(1'b1, 60, 2);
        n_checks++; if ({ask_valid, best_ask, ask_qty} !== {1'b1, 8'd60, 4'd2}) begin n_fail++; $display("FAIL eq_ask_rest: got v=%b p=%0d q=%0d want 1/60/2", ask_valid, best_ask, ask_qty); end
        send_order(1'b0, 60, 5);
        n_checks++; if (r_flags !== 1) begin n_fail++; $display("FAIL eq_pulses: got %0d want 1", r_flags); end
        n_checks++; if ({r_buy, r_sell, r_mqty} !== {8'd60, 8'd60, 4'd2}) begin n_fail++; $display("FAIL eq_trade: got %0d/%0d/%0d want 60/60/2", r_buy, r_sell, r_mqty); end
        n_checks++; if (r_cycles !== 4) begin n_fail++; $display("FAIL eq_cycles: got %0d want 4", r_cycles); end
        n_checks++; if ({ask_valid, best_ask, ask_qty} !== {1'b0, 8'd0, 4'd0}) begin n_fail++; $display("FAIL eq_ask_clear: got v=%b p=%0d q=%0d want 0/0/0", ask_valid, best_ask, ask_qty); end
        n_checks++; if ({bid_valid, best_bid, bid_qty} !== {1'b1, 8'd60, 4'd3}) begin n_fail++; $display("FAIL eq_bid: got v=%b p=%0d q=%0d want 1/60/3", bid_valid, best_bid, bid_qty); end
        n_checks++; if (trade_count !== 16'd2) begin n_fail++; $display("FAIL eq_count: got %0d want 2", trade_count); end
    endtask

    task automatic test_replace();
        do_reset();
        send_order(1'b0, 50, 1);
        send_order(1'b0, 40, 4);
        n_checks++; if (r_flags !== 0 || r_cycles !== 3) begin n_fail++; $display("FAIL worse_bid: got pulses=%0d cycles=%0d want 0/3", r_flags, r_cycles); end
        n_checks++; if ({bid_valid, best_bid, bid_qty} !== {1'b1, 8'd50, 4'd1}) begin n_fail++; $display("FAIL worse_book: got v=%b p=%0d q=%0d want 1/50/1", bid_valid, best_bid, bid_qty); end
        send_order(1'b0, 55, 4);
        n_checks++; if ({bid_valid, best_bid, bid_qty} !== {1'b1, 8'd55, 4'd4}) begin n_fail++; $display("FAIL better_book: got v=%b p=%0d q=%0d want 1/55/4", bid_valid, best_bid, bid_qty); end
        n_checks++; if (trade_count !== 16'd0) begin n_fail++; $display("FAIL replace_count: got %0d want 0", trade_count); end
    endtask

    task automatic test_enable_zero_qty();
        @(negedge clk);
        enable      = 1'b0;
        order_valid = 1'b1;
        order_side  = 1'b0;
        order_price = 8'd90;
        order_qty   = 4'd2;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++; if (order_ready !== 1'b1) begin n_fail++; $display("FAIL disabled_ready[%0d]: got %b want 1", i, order_ready); end
        end
        order_valid = 1'b0;
        n_checks++; if ({bid_valid, best_bid, bid_qty} !== {1'b1, 8'd55, 4'd4}) begin n_fail++; $display("FAIL disabled_book: got v=%b p=%0d q=%0d want 1/55/4", bid_valid, best_bid, bid_qty); end
        enable = 1'b1;
        send_order(1'b0, 70, 0);
        n_checks++; if (r_cycles !== 2) begin n_fail++; $display("FAIL zero_cycles: got %0d want 2", r_cycles); end
        n_checks++; if (r_flags !== 0) begin n_fail++; $display("FAIL zero_flag: got %0d want 0", r_flags); end
        n_checks++; if ({bid_valid, best_bid, bid_qty} !== {1'b1, 8'd55, 4'd4}) begin n_fail++; $display("FAIL zero_book: got v=%b p=%0d q=%0d want 1/55/4", bid_valid, best_bid, bid_qty); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] seen;
        // Sell 60x1 does not cross bid 55. The first copy rests and the second
        // copy (not strictly better) is discarded.
        @(negedge clk);
        order_valid = 1'b1;
        order_side  = 1'b1;
        order_price = 8'd60;
        order_qty   = 4'd1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            seen[i] = order_ready;
        end
        order_valid = 1'b0;
        n_checks++; if (seen !== 4'b0100) begin n_fail++; $display("FAIL b2b_ready: got %b want 0100 (msb=cycle4)", seen); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if ({order_ready, ask_valid, best_ask, ask_qty} !== {1'b1, 1'b1, 8'd60, 4'd1}) begin n_fail++; $display("FAIL b2b_book: got r=%b v=%b p=%0d q=%0d want 1/1/60/1", order_ready, ask_valid, best_ask, ask_qty); end
    endtask

    task automatic test_reset_mid_order();
        int pulses;
        pulses = 0;
        @(negedge clk);
        order_valid = 1'b1;
        order_side  = 1'b1;
        order_price = 8'd50;
        order_qty   = 4'd2;
        @(posedge clk);
        @(negedge clk);
        order_valid = 1'b0;
        reset = 1'b0;
        #1;
        n_checks++; if (order_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", order_ready); end
        n_checks++; if ({bid_valid, ask_valid, best_bid, best_ask, bid_qty, ask_qty} !== 26'h0) begin n_fail++; $display("FAIL midrst_book: got %h want 0", {bid_valid, ask_valid, best_bid, best_ask, bid_qty, ask_qty}); end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 1) reset = 1'b1;
            if (match_flag === 1'b1) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL midrst_flag: got %0d pulses want 0", pulses); end
        n_checks++; if (trade_count !== 16'd0) begin n_fail++; $display("FAIL midrst_count: got %0d want 0", trade_count); end
    endtask

    task automatic test_saturate();
        send_order(1'b0, 50, 2);
        @(negedge clk);
        force dut.trade_count = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.trade_count;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (trade_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_preload: got %h want ffff", trade_count); end
        send_order(1'b1, 49, 1);
        n_checks++; if (r_flags !== 1) begin n_fail++; $display("FAIL sat_pulses: got %0d want 1", r_flags); end
        n_checks++; if (trade_count !== 16'hFFFF) begin n_fail++; $display("FAIL sat_count: got %h want ffff", trade_count); end
        n_checks++; if ({bid_valid, best_bid, bid_qty} !== {1'b1, 8'd50, 4'd1}) begin n_fail++; $display("FAIL sat_book: got v=%b p=%0d q=%0d want 1/50/1", bid_valid, best_bid, bid_qty); end
    endtask

    initial begin
        enable = 1'b1;
        test_reset();
        test_rest_bid();
        test_sell_cross();
        test_equal_cross_remainder();
        test_replace();
        test_enable_zero_qty();
        test_back_to_back();
        test_reset_mid_order();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
